mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and shared-memory signals of the memory arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [1:0]        d_byte_enable;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic [1:0]        pmem_byte_enable;
    logic [DATA_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              grant_d;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address,
               pmem_wdata, pmem_byte_enable, grant_d
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_byte_enable, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address,
               pmem_wdata, pmem_byte_enable, grant_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between instruction and data sides.
// Every output is a register; the request is latched on grant and replayed until pmem_resp.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              grant_d_d;
    logic              pmem_read_d, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_d;
    logic [DATA_W-1:0] pmem_wdata_d;
    logic [1:0]        pmem_be_d;
    logic              i_resp_d, d_resp_d;
    logic [DATA_W-1:0] i_rdata_d, d_rdata_d;
    logic              d_req, pick_i;

    assign d_req  = bus.d_read | bus.d_write;
    // On a tie the instruction side wins only if the data side owned the last grant.
    assign pick_i = bus.i_read & (~d_req | last_d_q);

    always_comb begin
        state_d        = state_q;
        last_d_d       = last_d_q;
        grant_d_d      = bus.grant_d;
        pmem_read_d    = bus.pmem_read;
        pmem_write_d   = bus.pmem_write;
        pmem_address_d = bus.pmem_address;
        pmem_wdata_d   = bus.pmem_wdata;
        pmem_be_d      = bus.pmem_byte_enable;
        i_resp_d       = 1'b0;
        d_resp_d       = 1'b0;
        i_rdata_d      = bus.i_rdata;
        d_rdata_d      = bus.d_rdata;
        if (state_q == IDLE && (bus.i_read || d_req)) begin
            state_d        = BUSY;
            last_d_d       = ~pick_i;
            grant_d_d      = ~pick_i;
            pmem_read_d    = pick_i | ~bus.d_write;
            pmem_write_d   = ~pick_i & bus.d_write;
            pmem_address_d = pick_i ? bus.i_address : bus.d_address;
            pmem_wdata_d   = pick_i ? '0 : bus.d_wdata;
            pmem_be_d      = pick_i ? 2'b11 : bus.d_byte_enable;
        end else if (state_q == BUSY && bus.pmem_resp) begin
            state_d      = DONE;
            pmem_read_d  = 1'b0;
            pmem_write_d = 1'b0;
            i_resp_d     = ~bus.grant_d;
            d_resp_d     = bus.grant_d;
            i_rdata_d    = (bus.pmem_read && !bus.grant_d) ? bus.pmem_rdata : bus.i_rdata;
            d_rdata_d    = (bus.pmem_read && bus.grant_d) ? bus.pmem_rdata : bus.d_rdata;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= IDLE;
            last_d_q             <= 1'b1;
            bus.grant_d          <= 1'b0;
            bus.pmem_read        <= 1'b0;
            bus.pmem_write       <= 1'b0;
            bus.pmem_address     <= '0;
            bus.pmem_wdata       <= '0;
            bus.pmem_byte_enable <= 2'b00;
            bus.i_resp           <= 1'b0;
            bus.d_resp           <= 1'b0;
            bus.i_rdata          <= '0;
            bus.d_rdata          <= '0;
        end else begin
            state_q              <= state_d;
            last_d_q             <= last_d_d;
            bus.grant_d          <= grant_d_d;
            bus.pmem_read        <= pmem_read_d;
            bus.pmem_write       <= pmem_write_d;
            bus.pmem_address     <= pmem_address_d;
            bus.pmem_wdata       <= pmem_wdata_d;
            bus.pmem_byte_enable <= pmem_be_d;
            bus.i_resp           <= i_resp_d;
            bus.d_resp           <= d_resp_d;
            bus.i_rdata          <= i_rdata_d;
            bus.d_rdata          <= d_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        d;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } req_t;
    typedef struct {
        logic        d;
        logic [15:0] data;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    req_t  mon_r;
    resp_t mon_s;
    int    n_chk = 0;
    int    n_fail = 0;
    int    resp_cnt = 0;
    int    grant_cnt = 0;
    int    lat = 0;
    logic  mem_en = 1'b1;
    logic  stray = 1'b0;
    logic  prev_strobe = 1'b0;
    logic  prev_i_resp = 1'b0;
    logic  prev_d_resp = 1'b0;
    logic [15:0] busy_addr = '0;
    logic [15:0] last_d = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return a ^ 16'h1274;
    endfunction

    // Memory model: answers in the third cycle a strobe is seen.
    always @(negedge clk) begin
        bus.pmem_resp  = stray;
        bus.pmem_rdata = 16'hBEEF;
        if (mem_en && (bus.pmem_read || bus.pmem_write)) begin
            lat++;
            if (lat == 3) begin
                bus.pmem_resp  = 1'b1;
                bus.pmem_rdata = mem_val(bus.pmem_address);
                lat = 0;
            end
        end else begin
            lat = 0;
        end
    end

    always @(negedge clk) begin
        if (bus.pmem_read || bus.pmem_write) begin
            if (!prev_strobe) begin
                grant_cnt++;
                busy_addr = bus.pmem_address;
                if (req_q.size() == 0) chk("grant_unexp", 1, 0);
                else begin
                    mon_r = req_q.pop_front();
                    chk("pmem_rd", 32'(bus.pmem_read), 32'(mon_r.rd));
                    chk("pmem_wr", 32'(bus.pmem_write), 32'(mon_r.wr));
                    chk("pmem_addr", 32'(bus.pmem_address), 32'(mon_r.addr));
                    chk("pmem_be", 32'(bus.pmem_byte_enable), 32'(mon_r.be));
                    chk("grant_d", 32'(bus.grant_d), 32'(mon_r.d));
                    if (mon_r.wr) chk("pmem_wdata", 32'(bus.pmem_wdata), 32'(mon_r.wdata));
                end
            end else begin
                chk("addr_hold", 32'(bus.pmem_address), 32'(busy_addr));
            end
        end
        prev_strobe = bus.pmem_read | bus.pmem_write;
        if (bus.i_resp || bus.d_resp) begin
            resp_cnt++;
            chk("resp_pulse", 32'({prev_i_resp & bus.i_resp, prev_d_resp & bus.d_resp}), 0);
            chk("resp_both", 32'(bus.i_resp & bus.d_resp), 0);
            if (resp_q.size() == 0) chk("resp_unexp", 1, 0);
            else begin
                mon_s = resp_q.pop_front();
                chk("resp_side", 32'(bus.d_resp), 32'(mon_s.d));
                if (bus.i_resp) chk("i_rdata", 32'(bus.i_rdata), 32'(mon_s.data));
                else chk("d_rdata", 32'(bus.d_rdata), 32'(mon_s.data));
            end
        end
        prev_i_resp = bus.i_resp;
        prev_d_resp = bus.d_resp;
    end

    task automatic issue_i(input logic [15:0] a);
        req_q.push_back('{d: 1'b0, rd: 1'b1, wr: 1'b0, addr: a, wdata: 16'h0, be: 2'b11});
        resp_q.push_back('{d: 1'b0, data: mem_val(a)});
        bus.i_address = a;
        bus.i_read = 1'b1;
    endtask

    task automatic issue_d(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] w, input logic [1:0] be);
        req_q.push_back('{d: 1'b1, rd: ~wr, wr: wr, addr: a, wdata: w, be: be});
        if (!wr) last_d = mem_val(a);
        resp_q.push_back('{d: 1'b1, data: last_d});
        bus.d_address = a;
        bus.d_wdata = w;
        bus.d_byte_enable = be;
        bus.d_read = rd;
        bus.d_write = wr;
    endtask

    task automatic wait_resp(input logic d, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(d ? bus.d_resp : bus.i_resp) && k < 100);
        chk(d ? "d_resp_seen" : "i_resp_seen", 32'(d ? bus.d_resp : bus.i_resp), 1);
    endtask

    task automatic drop_i();
        @(posedge clk);
        #1 bus.i_read = 1'b0;
    endtask

    task automatic drop_d();
        @(posedge clk);
        #1;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int snap_r;
        int snap_g;
        bus.i_read = 1'b0;
        bus.i_address = '0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
        bus.d_byte_enable = 2'b00;
        bus.d_address = '0;
        bus.d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_strobe", 32'({bus.pmem_read, bus.pmem_write}), 0);
        chk("rst_resp", 32'({bus.i_resp, bus.d_resp}), 0);
        chk("rst_addr", 32'(bus.pmem_address), 0);
        chk("rst_wdata", 32'(bus.pmem_wdata), 0);
        chk("rst_be", 32'(bus.pmem_byte_enable), 0);
        chk("rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 0);
        chk("rst_grant_d", 32'(bus.grant_d), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Tie straight after reset: instruction first, data granted two cycles after i_resp.
        @(posedge clk);
        #1;
        issue_i(16'h0100);
        issue_d(1'b1, 1'b0, 16'h0200, 16'h0, 2'b11);
        wait_resp(1'b0, k);
        drop_i();
        @(negedge clk);
        chk("tie_idle_gap", 32'(bus.pmem_read), 0);
        @(negedge clk);
        chk("tie_d_grant", 32'({bus.pmem_read, bus.grant_d}), 32'h3);
        wait_resp(1'b1, k);
        drop_d();

        // Single fetch with latency checks.
        @(posedge clk);
        #1 issue_i(16'h0040);
        @(negedge clk);
        chk("lat_req_cycle", 32'(bus.pmem_read), 0);
        @(negedge clk);
        chk("lat_strobe", 32'(bus.pmem_read), 1);
        wait_resp(1'b0, k);
        chk("lat_resp", k, 3);
        chk("i_rdata_0040", 32'(bus.i_rdata), 32'h1234);
        drop_i();

        // Tie after an instruction grant goes to the data side.
        @(posedge clk);
        #1;
        issue_d(1'b1, 1'b0, 16'h0300, 16'h0, 2'b11);
        issue_i(16'h0140);
        wait_resp(1'b1, k);
        drop_d();
        wait_resp(1'b0, k);
        drop_i();

        // Address change while BUSY must not reach pmem.
        @(posedge clk);
        #1 issue_d(1'b1, 1'b0, 16'h2000, 16'h0, 2'b11);
        @(posedge clk);
        #1;
        bus.d_address = 16'h3000;
        bus.d_wdata = 16'hFFFF;
        wait_resp(1'b1, k);
        drop_d();

        // Byte write, then read+write together counts as a write; d_rdata stays put.
        @(posedge clk);
        #1 issue_d(1'b0, 1'b1, 16'h1001, 16'hAB00, 2'b10);
        wait_resp(1'b1, k);
        drop_d();
        @(posedge clk);
        #1 issue_d(1'b1, 1'b1, 16'h1002, 16'h00CD, 2'b01);
        wait_resp(1'b1, k);
        chk("d_rdata_kept", 32'(bus.d_rdata), 32'(mem_val(16'h2000)));
        drop_d();

        // Reset during BUSY, then a stray pmem_resp in IDLE.
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        snap_r = resp_cnt;
        snap_g = grant_cnt;
        req_q.push_back('{d: 1'b1, rd: 1'b1, wr: 1'b0, addr: 16'h4000, wdata: 16'h0, be: 2'b11});
        bus.d_address = 16'h4000;
        bus.d_byte_enable = 2'b11;
        bus.d_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rb_strobe", 32'(bus.pmem_read), 1);
        #2;
        rst_n = 1'b0;
        bus.d_read = 1'b0;
        #1 chk("rb_async_drop", 32'({bus.pmem_read, bus.pmem_write, bus.grant_d}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_en = 1'b1;
        stray = 1'b1;
        @(posedge clk);
        #1 stray = 1'b0;
        repeat (6) @(negedge clk);
        chk("rb_no_resp", resp_cnt, snap_r);
        chk("rb_grants", grant_cnt, snap_g + 1);

        // Tie after the second reset goes to the instruction side again.
        @(posedge clk);
        #1;
        issue_i(16'h0600);
        issue_d(1'b1, 1'b0, 16'h0500, 16'h0, 2'b11);
        wait_resp(1'b0, k);
        drop_i();
        wait_resp(1'b1, k);
        drop_d();

        // Back-to-back fetches with i_read held throughout.
        @(posedge clk);
        #1;
        snap_r = resp_cnt;
        snap_g = grant_cnt;
        issue_i(16'h0080);
        issue_i(16'h0080);
        wait_resp(1'b0, k);
        wait_resp(1'b0, k);
        chk("b2b_gap", k, 5);
        drop_i();
        repeat (6) @(negedge clk);
        chk("b2b_resps", resp_cnt, snap_r + 2);
        chk("b2b_grants", grant_cnt, snap_g + 2);

        chk("req_q_empty", req_q.size(), 0);
        chk("resp_q_empty", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
